// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 sequencing controller.
package aes_pkg;

    localparam int AES_BLK_W      = 128;
    localparam int AES_BYTES      = 16;
    localparam int AES128_NROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ROUND   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } aes_seq_state_t;

endpackage

// File: rtl/aes_byte_serializer.sv
// 128-to-8 output shift register: loaded once per block, streams byte 0 first
// over a valid/ready port and flags the final byte.
module aes_byte_serializer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [AES_BLK_W-1:0] data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [7:0]           data_out_o,
    output logic                 out_last_o,
    output logic                 done_o
);

    localparam int CNT_W = $clog2(AES_BYTES);

    logic [AES_BLK_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 xfer;

    assign out_valid_o = valid_q;
    assign data_out_o  = sreg_q[AES_BLK_W-1 -: 8];
    assign out_last_o  = valid_q & (cnt_q == CNT_W'(AES_BYTES - 1));
    assign xfer        = valid_q & out_ready_i;
    assign done_o      = xfer & out_last_o;

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            sreg_d  = data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            sreg_d = {sreg_q[AES_BLK_W-9:0], 8'h00};
            cnt_d  = cnt_q + CNT_W'(1);
            if (out_last_o) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/aes_seq_ctrl.sv
// Sequencing controller for the iterative AES-128 round datapath.
// Optional AES_SEQ_CTRL_PERF_EN adds a completed-block counter output blk_count.
module aes_seq_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS = AES128_NROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_load,
    output logic         dp_round_en,
    output logic [3:0]   dp_round,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   data_out,
    output logic         out_last,
`ifdef AES_SEQ_CTRL_PERF_EN
    output logic [31:0]  blk_count,
`endif
    output logic [2:0]   dbg_state
);

    // Both ports are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a source holds valid and payload until then.
    aes_seq_state_t state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [127:0]   pt_q, key_q;
    logic           accept, capture, drain_done;

    assign accept    = in_valid & in_ready;
    assign dp_state  = pt_q;
    assign dp_key    = key_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        in_ready    = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_round    = '0;
        dp_last     = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dp_load = 1'b1;
                round_d = 4'd1;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                dp_round_en = 1'b1;
                dp_round    = round_q;
                dp_last     = (round_q == 4'(NROUNDS));
                round_d     = round_q + 4'd1;
                if (dp_last) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            pt_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            if (accept) begin
                pt_q  <= data_in;
                key_q <= key;
            end
        end
    end

    // dp_result is final in CAPTURE: the datapath updated on the last round edge.
    aes_byte_serializer u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (capture),
        .data_i      (dp_result),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_out_o  (data_out),
        .out_last_o  (out_last),
        .done_o      (drain_done)
    );

`ifdef AES_SEQ_CTRL_PERF_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else if (drain_done) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule
